// File: rtl/bg_frame_fill_if.sv
// Start/done handshake and pixel-write channel between the background fill
// engine (master) and the swap controller / framebuffer write sink (slave).
interface bg_frame_fill_if #(
   parameter int unsigned ADDR_W = 20
);
   logic              bg_start;
   logic              bg_start_ack;
   logic              bg_done;
   logic              bg_done_ack;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   modport master (
      input  bg_start, bg_done_ack, wr_ready,
      output bg_start_ack, bg_done, wr_valid, wr_addr, wr_data
   );

   modport slave (
      output bg_start, bg_done_ack, wr_ready,
      input  bg_start_ack, bg_done, wr_valid, wr_addr, wr_data
   );
endinterface

// File: rtl/bg_frame_fill.sv
// Background frame fill engine: on a start request, writes a gradient pattern
// tagged with a frame counter into the back framebuffer, then signals
// completion through a 4-phase done/ack handshake.
module bg_frame_fill #(
   parameter int unsigned      H_PIX  = 800,
   parameter int unsigned      V_PIX  = 600,
   parameter int unsigned      ADDR_W = 20,
   parameter logic [ADDR_W-1:0] BASE0 = '0,
   parameter logic [ADDR_W-1:0] BASE1 = ADDR_W'(32'h80000)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_front_sel,
   bg_frame_fill_if.master   io_bus
);

   localparam int unsigned X_W = ($clog2(H_PIX) < 8) ? 8 : $clog2(H_PIX);
   localparam int unsigned Y_W = ($clog2(V_PIX) < 8) ? 8 : $clog2(V_PIX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DONE,
      S_RELEASE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [X_W-1:0]    r_x;
   logic [X_W-1:0]    w_x_nxt;
   logic [Y_W-1:0]    r_y;
   logic [Y_W-1:0]    w_y_nxt;
   logic [7:0]        r_frame_cnt;
   logic [7:0]        w_frame_cnt_nxt;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] w_wr_addr_nxt;
   logic [31:0]       r_wr_data;
   logic [31:0]       w_wr_data_nxt;
   logic              r_wr_valid;
   logic              w_wr_valid_nxt;
   logic              r_start_ack;
   logic              w_start_ack_nxt;
   logic              r_done;
   logic              w_done_nxt;
   logic              w_last_x;
   logic              w_last_y;

   assign w_last_x = (r_x == X_W'(H_PIX - 1));
   assign w_last_y = (r_y == Y_W'(V_PIX - 1));

   assign io_bus.bg_start_ack = r_start_ack;
   assign io_bus.bg_done      = r_done;
   assign io_bus.wr_valid     = r_wr_valid;
   assign io_bus.wr_addr      = r_wr_addr;
   assign io_bus.wr_data      = r_wr_data;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered outputs and pixel/frame counters
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x         <= '0;
         r_y         <= '0;
         r_frame_cnt <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_valid  <= 1'b0;
         r_start_ack <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_wr_data   <= w_wr_data_nxt;
         r_wr_valid  <= w_wr_valid_nxt;
         r_start_ack <= w_start_ack_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that every port is driven straight from a flop.
   always_comb begin
      w_state_nxt     = r_state;
      w_x_nxt         = r_x;
      w_y_nxt         = r_y;
      w_frame_cnt_nxt = r_frame_cnt;
      w_wr_addr_nxt   = r_wr_addr;
      w_wr_data_nxt   = r_wr_data;
      w_wr_valid_nxt  = r_wr_valid;
      w_start_ack_nxt = 1'b0;
      w_done_nxt      = r_done;

      case (r_state)
         S_IDLE: begin
            if (io_bus.bg_start) begin
               // Back buffer is the one not being displayed at this instant.
               w_state_nxt     = S_FILL;
               w_start_ack_nxt = 1'b1;
               w_x_nxt         = '0;
               w_y_nxt         = '0;
               w_wr_addr_nxt   = i_front_sel ? BASE0 : BASE1;
               w_wr_data_nxt   = {24'h000000, r_frame_cnt};
               w_wr_valid_nxt  = 1'b1;
            end
         end

         S_FILL: begin
            if (io_bus.wr_ready) begin
               if (w_last_x && w_last_y) begin
                  w_wr_valid_nxt = 1'b0;
                  w_done_nxt     = 1'b1;
                  w_state_nxt    = S_DONE;
               end else begin
                  w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
                  if (w_last_x) begin
                     w_x_nxt = '0;
                     w_y_nxt = r_y + Y_W'(1);
                  end else begin
                     w_x_nxt = r_x + X_W'(1);
                  end
                  w_wr_data_nxt = {8'h00, w_x_nxt[7:0], w_y_nxt[7:0], r_frame_cnt};
               end
            end
         end

         S_DONE: begin
            if (io_bus.bg_done_ack) begin
               w_done_nxt  = 1'b0;
               w_state_nxt = S_RELEASE;
            end
         end

         S_RELEASE: begin
            if (!io_bus.bg_done_ack) begin
               w_frame_cnt_nxt = r_frame_cnt + 8'd1;
               w_state_nxt     = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bg_frame_fill.sv
// Directed testbench for bg_frame_fill with a 4x2 frame, buffers at 0 and 16.
module tb_bg_frame_fill;
   localparam int unsigned ADDR_W = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic front_sel = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [ADDR_W-1:0] acc_addr[$];
   logic [31:0]       acc_data[$];
   int                n_stall_chg;
   int                ack_hi;
   int                timed_out;

   bg_frame_fill_if #(.ADDR_W(ADDR_W)) bus();

   bg_frame_fill #(
      .H_PIX (4),
      .V_PIX (2),
      .ADDR_W(ADDR_W),
      .BASE0 (20'd0),
      .BASE1 (20'd16)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_front_sel(front_sel),
      .io_bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_data(input int x, input int y, input int f);
      return {8'h00, 8'(x), 8'(y), 8'(f)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives wr_ready and records every accepted write until wr_valid falls.
   task automatic run_fill(input bit rnd, input int flip_at);
      logic              r;
      logic              prev_stall;
      logic [ADDR_W-1:0] prev_addr;
      logic [31:0]       prev_data;
      acc_addr.delete();
      acc_data.delete();
      n_stall_chg = 0;
      ack_hi      = 0;
      timed_out   = 1;
      prev_stall  = 1'b0;
      prev_addr   = '0;
      prev_data   = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc == flip_at) front_sel = ~front_sel;
         if (cyc > 0 && bus.bg_start_ack !== 1'b0) ack_hi++;
         if (prev_stall && (bus.wr_valid !== 1'b1 || bus.wr_addr !== prev_addr ||
                            bus.wr_data !== prev_data)) n_stall_chg++;
         if (bus.wr_valid !== 1'b1) begin
            timed_out = 0;
            break;
         end
         if (rnd && (cyc == 1 || cyc == 2)) r = 1'b0;
         else if (rnd) r = 1'($urandom_range(0, 1));
         else r = 1'b1;
         bus.wr_ready = r;
         if (r) begin
            acc_addr.push_back(bus.wr_addr);
            acc_data.push_back(bus.wr_data);
         end
         prev_stall = !r;
         prev_addr  = bus.wr_addr;
         prev_data  = bus.wr_data;
         tick();
      end
      bus.wr_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.bg_start = 1'b0; bus.bg_done_ack = 1'b0; bus.wr_ready = 1'b0;
      rst_n = 1'b0;
      #12;
      checks++; if (bus.wr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.wr_valid); end
      checks++; if (bus.bg_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.bg_done); end
      checks++; if (bus.bg_start_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", bus.bg_start_ack); end
      checks++; if (bus.wr_addr !== 20'd0) begin failures++; $display("FAIL reset_addr: got %0h want 0", bus.wr_addr); end
      checks++; if (bus.wr_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %0h want 0", bus.wr_data); end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (bus.wr_valid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b want 0", bus.wr_valid); end
      end
   endtask

   task automatic test_basic_frame();
      front_sel = 1'b1; bus.bg_start = 1'b1;
      tick();
      bus.bg_start = 1'b0;
      checks++; if (bus.bg_start_ack !== 1'b1) begin failures++; $display("FAIL basic_ack: got %b want 1", bus.bg_start_ack); end
      checks++; if (bus.wr_addr !== 20'd0) begin failures++; $display("FAIL basic_first_addr: got %0d want 0", bus.wr_addr); end
      run_fill(1'b0, -1);
      checks++; if (timed_out != 0) begin failures++; $display("FAIL basic_timeout: got %0d want 0", timed_out); end
      checks++; if (acc_addr.size() != 8) begin failures++; $display("FAIL basic_count: got %0d want 8", acc_addr.size()); end
      checks++; if (ack_hi != 0) begin failures++; $display("FAIL basic_ack_width: got %0d extra want 0", ack_hi); end
      for (int i = 0; i < acc_addr.size() && i < 8; i++) begin
         checks++; if (acc_addr[i] !== 20'(i)) begin failures++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, acc_addr[i], i); end
         checks++; if (acc_data[i] !== exp_data(i % 4, i / 4, 0)) begin failures++; $display("FAIL basic_data[%0d]: got %h want %h", i, acc_data[i], exp_data(i % 4, i / 4, 0)); end
      end
      checks++; if (bus.bg_done !== 1'b1) begin failures++; $display("FAIL basic_done: got %b want 1", bus.bg_done); end
      tick(); tick();
      checks++; if (bus.bg_done !== 1'b1) begin failures++; $display("FAIL basic_done_hold: got %b want 1", bus.bg_done); end
      bus.bg_done_ack = 1'b1;
      tick();
      checks++; if (bus.bg_done !== 1'b0) begin failures++; $display("FAIL basic_done_drop: got %b want 0", bus.bg_done); end
      bus.bg_done_ack = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      front_sel = 1'b1; bus.bg_start = 1'b1;
      tick();
      bus.bg_start = 1'b0;
      run_fill(1'b1, -1);
      checks++; if (timed_out != 0) begin failures++; $display("FAIL bp_timeout: got %0d want 0", timed_out); end
      checks++; if (acc_addr.size() != 8) begin failures++; $display("FAIL bp_count: got %0d want 8", acc_addr.size()); end
      checks++; if (n_stall_chg != 0) begin failures++; $display("FAIL bp_stall_stable: got %0d changes want 0", n_stall_chg); end
      for (int i = 0; i < acc_addr.size() && i < 8; i++) begin
         checks++; if (acc_addr[i] !== 20'(i)) begin failures++; $display("FAIL bp_addr[%0d]: got %0d want %0d", i, acc_addr[i], i); end
         checks++; if (acc_data[i] !== exp_data(i % 4, i / 4, 1)) begin failures++; $display("FAIL bp_data[%0d]: got %h want %h", i, acc_data[i], exp_data(i % 4, i / 4, 1)); end
      end
      bus.bg_done_ack = 1'b1;
      tick();
      bus.bg_done_ack = 1'b0;
      tick();
   endtask

   task automatic test_buffer_select();
      front_sel = 1'b0; bus.bg_start = 1'b1;
      tick();
      bus.bg_start = 1'b0;
      run_fill(1'b0, 3);
      checks++; if (acc_addr.size() != 8) begin failures++; $display("FAIL bufsel_count: got %0d want 8", acc_addr.size()); end
      for (int i = 0; i < acc_addr.size() && i < 8; i++) begin
         checks++; if (acc_addr[i] !== 20'(16 + i)) begin failures++; $display("FAIL bufsel_addr[%0d]: got %0d want %0d", i, acc_addr[i], 16 + i); end
         checks++; if (acc_data[i] !== exp_data(i % 4, i / 4, 2)) begin failures++; $display("FAIL bufsel_data[%0d]: got %h want %h", i, acc_data[i], exp_data(i % 4, i / 4, 2)); end
      end
      bus.bg_done_ack = 1'b1;
      tick();
      bus.bg_done_ack = 1'b0;
      tick();
   endtask

   // Leaves the DUT in the first FILL cycle of frame 4.
   task automatic test_done_handshake();
      front_sel = 1'b1; bus.bg_start = 1'b1;
      tick();
      bus.bg_start = 1'b0;
      run_fill(1'b0, -1);
      checks++; if (acc_addr.size() != 8) begin failures++; $display("FAIL hs_count: got %0d want 8", acc_addr.size()); end
      checks++; if (bus.bg_done !== 1'b1) begin failures++; $display("FAIL hs_done: got %b want 1", bus.bg_done); end
      tick();
      checks++; if (bus.bg_done !== 1'b1) begin failures++; $display("FAIL hs_done_wait: got %b want 1", bus.bg_done); end
      bus.bg_done_ack = 1'b1; bus.bg_start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.bg_done !== 1'b0) begin failures++; $display("FAIL hs_done_drop[%0d]: got %b want 0", i, bus.bg_done); end
         checks++; if (bus.bg_start_ack !== 1'b0) begin failures++; $display("FAIL hs_no_idle[%0d]: got %b want 0", i, bus.bg_start_ack); end
      end
      bus.bg_done_ack = 1'b0;
      tick();
      checks++; if (bus.bg_start_ack !== 1'b0 || bus.wr_valid !== 1'b0) begin failures++; $display("FAIL hs_idle: got ack=%b valid=%b want 0 0", bus.bg_start_ack, bus.wr_valid); end
      tick();
      bus.bg_start = 1'b0;
      checks++; if (bus.bg_start_ack !== 1'b1) begin failures++; $display("FAIL hs_restart_ack: got %b want 1", bus.bg_start_ack); end
      checks++; if (bus.wr_data !== exp_data(0, 0, 4)) begin failures++; $display("FAIL hs_frame_cnt: got %h want %h", bus.wr_data, exp_data(0, 0, 4)); end
   endtask

   // Entered in the first FILL cycle of frame 4.
   task automatic test_early_start();
      bus.bg_start = 1'b1;
      run_fill(1'b0, -1);
      checks++; if (acc_addr.size() != 8) begin failures++; $display("FAIL early_count: got %0d want 8", acc_addr.size()); end
      checks++; if (ack_hi != 0) begin failures++; $display("FAIL early_ack_fill: got %0d want 0", ack_hi); end
      checks++; if (bus.bg_start_ack !== 1'b0) begin failures++; $display("FAIL early_ack_done: got %b want 0", bus.bg_start_ack); end
      bus.bg_done_ack = 1'b1;
      tick();
      checks++; if (bus.bg_start_ack !== 1'b0) begin failures++; $display("FAIL early_ack_release: got %b want 0", bus.bg_start_ack); end
      bus.bg_done_ack = 1'b0;
      tick();
      checks++; if (bus.bg_start_ack !== 1'b0 || bus.wr_valid !== 1'b0) begin failures++; $display("FAIL early_idle: got ack=%b valid=%b want 0 0", bus.bg_start_ack, bus.wr_valid); end
      tick();
      bus.bg_start = 1'b0;
      checks++; if (bus.bg_start_ack !== 1'b1 || bus.wr_valid !== 1'b1) begin failures++; $display("FAIL early_restart: got ack=%b valid=%b want 1 1", bus.bg_start_ack, bus.wr_valid); end
      checks++; if (bus.wr_data !== exp_data(0, 0, 5)) begin failures++; $display("FAIL early_frame_cnt: got %h want %h", bus.wr_data, exp_data(0, 0, 5)); end
   endtask

   // Entered in the first FILL cycle of frame 5; ack is already high on DONE entry.
   task automatic test_back_to_back();
      bus.bg_done_ack = 1'b1;
      run_fill(1'b0, -1);
      checks++; if (acc_addr.size() != 8) begin failures++; $display("FAIL b2b_count: got %0d want 8", acc_addr.size()); end
      if (acc_data.size() == 8) begin
         checks++; if (acc_data[7] !== exp_data(3, 1, 5)) begin failures++; $display("FAIL b2b_last_data: got %h want %h", acc_data[7], exp_data(3, 1, 5)); end
      end
      checks++; if (bus.bg_done !== 1'b1) begin failures++; $display("FAIL b2b_done_pulse: got %b want 1", bus.bg_done); end
      tick();
      checks++; if (bus.bg_done !== 1'b0) begin failures++; $display("FAIL b2b_done_exit: got %b want 0", bus.bg_done); end
      bus.bg_done_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      front_sel = 1'b1; bus.bg_start = 1'b1;
      tick();
      bus.bg_start = 1'b0;
      checks++; if (bus.wr_data !== exp_data(0, 0, 6)) begin failures++; $display("FAIL rstmid_pre_cnt: got %h want %h", bus.wr_data, exp_data(0, 0, 6)); end
      bus.wr_ready = 1'b1;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.wr_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b want 0", bus.wr_valid); end
      checks++; if (bus.wr_addr !== 20'd0) begin failures++; $display("FAIL rstmid_addr: got %0d want 0", bus.wr_addr); end
      checks++; if (bus.bg_done !== 1'b0 || bus.bg_start_ack !== 1'b0) begin failures++; $display("FAIL rstmid_hs: got done=%b ack=%b want 0 0", bus.bg_done, bus.bg_start_ack); end
      #1 rst_n = 1'b1;
      bus.wr_ready = 1'b0;
      tick();
      checks++; if (bus.wr_valid !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got %b want 0", bus.wr_valid); end
      bus.bg_start = 1'b1;
      tick();
      bus.bg_start = 1'b0;
      checks++; if (bus.bg_start_ack !== 1'b1) begin failures++; $display("FAIL rstmid_restart: got %b want 1", bus.bg_start_ack); end
      checks++; if (bus.wr_data !== exp_data(0, 0, 0)) begin failures++; $display("FAIL rstmid_cnt_cleared: got %h want %h", bus.wr_data, exp_data(0, 0, 0)); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_buffer_select();
      test_done_handshake();
      test_early_start();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
